// File: rtl/asrv32_memoryaccess.sv
// asrv32_memoryaccess: memory-access stage of the ASRV32 core.
// Turns LOAD/STORE instructions into single Wishbone-classic transactions.
// It generates the byte-lane selects, replicates the store data, and
// extracts and sign/zero-extends load data. The core is stalled while a
// transaction is outstanding, and the access is aborted if no ack arrives
// within TIMEOUT_CYCLES.
// Optional build macro: ASRV32_MISALIGN_TRAP_EN. When it is defined, a
// misaligned half/word access is trapped instead of being sent to the bus.

`ifndef ASRV32_OPCODES
`define ASRV32_OPCODES
`define OPCODE_WIDTH 11
`define RTYPE  0
`define ITYPE  1
`define LOAD   2
`define STORE  3
`define BRANCH 4
`define JAL    5
`define JALR   6
`define LUI    7
`define AUIPC  8
`define SYSTEM 9
`define FENCE  10
`endif

module asrv32_memoryaccess #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_ce,
    input  logic [`OPCODE_WIDTH-1:0] i_opcode,
    input  logic [2:0]               i_funct3,
    input  logic [31:0]              i_addr,
    input  logic [31:0]              i_rs2_data,
    output logic [31:0]              o_load_data,
    output logic                     o_stall,
    output logic                     o_done,
    output logic                     o_bus_err,
    output logic                     o_misaligned,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [31:0]              o_wb_addr,
    output logic [31:0]              o_wb_data,
    output logic [3:0]               o_wb_sel,
    input  logic                     i_wb_ack,
    input  logic [31:0]              i_wb_data
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_funct3;
    logic        r_is_load;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_sz_byte;
    logic        w_sz_half;
    logic        w_misaligned;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [7:0]  w_cnt_nxt;

    logic        w_r_sz_byte;
    logic        w_r_sz_half;
    logic        w_r_signed;
    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [31:0] w_ext;

    // Only the LOAD/STORE bits of the one-hot opcode matter here
    logic        w_unused_opcode;
    assign w_unused_opcode = ^i_opcode;

    assign w_is_load  = i_opcode[`LOAD];
    assign w_is_store = i_opcode[`STORE];
    assign w_is_mem   = w_is_load | w_is_store;

    // funct3[1:0]: 00 byte, 01 half, anything else (incl. reserved) word
    assign w_sz_byte  = (i_funct3[1:0] == 2'b00);
    assign w_sz_half  = (i_funct3[1:0] == 2'b01);

    assign w_cnt_nxt  = r_cnt + 8'd1;

`ifdef ASRV32_MISALIGN_TRAP_EN
    logic r_misaligned;
    assign w_misaligned = w_is_mem &
                          ((w_sz_half & i_addr[0]) |
                           (!w_sz_byte && !w_sz_half && (i_addr[1:0] != 2'b00)));
    assign o_misaligned = r_misaligned;
`else
    assign w_misaligned = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    // Lane select and store-data replication for the incoming instruction
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = i_rs2_data;
        if (w_sz_byte) begin
            w_sel   = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_rs2_data[7:0]}};
        end else if (w_sz_half) begin
            w_sel   = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_rs2_data[15:0]}};
        end
    end

    assign w_r_sz_byte = (r_funct3[1:0] == 2'b00);
    assign w_r_sz_half = (r_funct3[1:0] == 2'b01);
    assign w_r_signed  = ~r_funct3[2];

    // Load extraction: shift the addressed lane down, then sign/zero-extend
    always_comb begin
        w_shamt = 5'd0;
        if (w_r_sz_byte) begin
            w_shamt = {r_addr_lo, 3'b000};
        end else if (w_r_sz_half) begin
            w_shamt = {r_addr_lo[1], 4'b0000};
        end
        w_shifted = i_wb_data >> w_shamt;
        w_ext     = w_shifted;
        if (w_r_sz_byte) begin
            w_ext = {{24{w_r_signed & w_shifted[7]}}, w_shifted[7:0]};
        end else if (w_r_sz_half) begin
            w_ext = {{16{w_r_signed & w_shifted[15]}}, w_shifted[15:0]};
        end
    end

    // Stage FSM: launch the bus cycle, wait for ack or timeout, then complete
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_addr_lo    <= 2'b00;
            r_funct3     <= 3'b000;
            r_is_load    <= 1'b0;
            o_load_data  <= 32'd0;
            o_stall      <= 1'b0;
            o_done       <= 1'b0;
            o_bus_err    <= 1'b0;
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_addr    <= 32'd0;
            o_wb_data    <= 32'd0;
            o_wb_sel     <= 4'b0000;
`ifdef ASRV32_MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            o_done       <= 1'b0;
            o_bus_err    <= 1'b0;
`ifdef ASRV32_MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (i_ce) begin
                        if (w_is_mem && !w_misaligned) begin
                            r_addr_lo <= i_addr[1:0];
                            r_funct3  <= i_funct3;
                            r_is_load <= w_is_load;
                            r_cnt     <= 8'd0;
                            o_wb_addr <= {i_addr[31:2], 2'b00};
                            o_wb_data <= w_wdata;
                            o_wb_sel  <= w_sel;
                            o_wb_we   <= w_is_store;
                            o_wb_cyc  <= 1'b1;
                            o_wb_stb  <= 1'b1;
                            o_stall   <= 1'b1;
                            r_state   <= ACCESS;
                        end else begin
                            // Non-memory op or trapped access: complete with no bus cycle
                            o_done      <= 1'b1;
                            o_load_data <= 32'd0;
`ifdef ASRV32_MISALIGN_TRAP_EN
                            r_misaligned <= w_misaligned;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (i_wb_ack) begin
                        // Ack wins even on the cycle the timeout would fire
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_stall     <= 1'b0;
                        o_done      <= 1'b1;
                        o_load_data <= r_is_load ? w_ext : 32'd0;
                        r_state     <= IDLE;
                    end else if (w_cnt_nxt == TIMEOUT_LIMIT) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_stall     <= 1'b0;
                        o_done      <= 1'b1;
                        o_bus_err   <= 1'b1;
                        o_load_data <= 32'd0;
                        r_cnt       <= w_cnt_nxt;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_asrv32_memoryaccess.sv
// Directed bench for asrv32_memoryaccess with a scoreboard of completions.
// The bench uses TIMEOUT_CYCLES=4 so that it can reach the timeout path quickly.

`ifndef ASRV32_OPCODES
`define ASRV32_OPCODES
`define OPCODE_WIDTH 11
`define RTYPE  0
`define ITYPE  1
`define LOAD   2
`define STORE  3
`define BRANCH 4
`define JAL    5
`define JALR   6
`define LUI    7
`define AUIPC  8
`define SYSTEM 9
`define FENCE  10
`endif

module tb_asrv32_memoryaccess;

    localparam int TO = 4;

    logic                     i_clk = 1'b0;
    logic                     i_rst_n = 1'b0;
    logic                     i_ce = 1'b0;
    logic [`OPCODE_WIDTH-1:0] i_opcode = '0;
    logic [2:0]               i_funct3 = 3'b000;
    logic [31:0]              i_addr = 32'd0;
    logic [31:0]              i_rs2_data = 32'd0;
    logic [31:0]              o_load_data;
    logic                     o_stall;
    logic                     o_done;
    logic                     o_bus_err;
    logic                     o_misaligned;
    logic                     o_wb_cyc;
    logic                     o_wb_stb;
    logic                     o_wb_we;
    logic [31:0]              o_wb_addr;
    logic [31:0]              o_wb_data;
    logic [3:0]               o_wb_sel;
    logic                     i_wb_ack = 1'b0;
    logic [31:0]              i_wb_data = 32'd0;

    always #5 i_clk = ~i_clk;

    asrv32_memoryaccess #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce), .i_opcode(i_opcode),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_rs2_data(i_rs2_data),
        .o_load_data(o_load_data), .o_stall(o_stall), .o_done(o_done),
        .o_bus_err(o_bus_err), .o_misaligned(o_misaligned),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
    );

    typedef struct {
        logic        chk_d;
        logic [31:0] d;
        logic        err;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    // captured at the first cycle after launch / over the transaction
    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_sel;
    logic        cap_we, cap_cyc, saw_cyc;
    int          stall_n, lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic chk_d, input logic [31:0] d, input logic err, input logic mis);
        exp_t e;
        e.chk_d = chk_d; e.d = d; e.err = err; e.mis = mis;
        sb.push_back(e);
    endtask

    task automatic issue(input int opb, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(posedge i_clk); #1;
        i_opcode = '0;
        i_opcode[opb] = 1'b1;
        i_funct3 = f3; i_addr = a; i_rs2_data = d; i_ce = 1'b1;
        @(posedge i_clk); #1;
        i_ce = 1'b0; i_opcode = '0;
    endtask

    // Runs from the cycle after the launch edge until o_done (bounded), then scores it.
    // ack_at: cycle index in which ack is presented (-1 = never).
    task automatic txn(input string tag, input int ack_at, input logic [31:0] rdata, input int exp_lat);
        exp_t e;
        stall_n = 0; lat = -1; saw_cyc = 1'b0;
        for (int c = 0; c < 300; c++) begin
            i_wb_ack  = (c == ack_at);
            i_wb_data = (c == ack_at) ? rdata : 32'd0;
            @(negedge i_clk);
            if (c == 0) begin
                cap_addr = o_wb_addr; cap_data = o_wb_data; cap_sel = o_wb_sel;
                cap_we = o_wb_we; cap_cyc = o_wb_cyc;
            end
            if (o_wb_cyc) saw_cyc = 1'b1;
            if (o_stall) stall_n++;
            if (o_done) begin
                lat = c + 1;
                break;
            end
            @(posedge i_clk); #1;
        end
        i_wb_ack = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (lat >= 0) begin
                if (e.chk_d) chk({tag, "_load_data"}, o_load_data, e.d);
                chk({tag, "_bus_err"}, {31'd0, o_bus_err}, {31'd0, e.err});
                chk({tag, "_misaligned"}, {31'd0, o_misaligned}, {31'd0, e.mis});
            end
        end
    endtask

    initial begin
        // reset state
        @(posedge i_clk); @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_cyc",   {31'd0, o_wb_cyc}, 32'd0);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_done",  {31'd0, o_done}, 32'd0);
        chk("rst_ldata", o_load_data, 32'd0);
        chk("rst_sel",   {28'd0, o_wb_sel}, 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // SW with ack presented in the third ACCESS cycle
        push(1'b0, 32'd0, 1'b0, 1'b0);
        issue(`STORE, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
        txn("sw", 2, 32'd0, 4);
        chk("sw_addr", cap_addr, 32'h0000_0104);
        chk("sw_sel", {28'd0, cap_sel}, 32'hF);
        chk("sw_data", cap_data, 32'hDEAD_BEEF);
        chk("sw_we", {31'd0, cap_we}, 32'd1);
        chk("sw_cyc", {31'd0, cap_cyc}, 32'd1);
        chk("sw_stall_cycles", stall_n, 3);

        // LB / LBU from the top byte lane
        push(1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
        issue(`LOAD, 3'b000, 32'h0000_0203, 32'd0);
        txn("lb", 0, 32'h8011_2233, 2);
        chk("lb_sel", {28'd0, cap_sel}, 32'h8);
        chk("lb_addr", cap_addr, 32'h0000_0200);
        chk("lb_we", {31'd0, cap_we}, 32'd0);

        push(1'b1, 32'h0000_0080, 1'b0, 1'b0);
        issue(`LOAD, 3'b100, 32'h0000_0203, 32'd0);
        txn("lbu", 0, 32'h8011_2233, 2);

        // SH / LH in the upper half
        push(1'b0, 32'd0, 1'b0, 1'b0);
        issue(`STORE, 3'b001, 32'h0000_0302, 32'h0000_ABCD);
        txn("sh", 0, 32'd0, 2);
        chk("sh_sel", {28'd0, cap_sel}, 32'hC);
        chk("sh_data", cap_data, 32'hABCD_ABCD);

        push(1'b1, 32'h0000_7FFF, 1'b0, 1'b0);
        issue(`LOAD, 3'b001, 32'h0000_0302, 32'd0);
        txn("lh_hi", 0, 32'h7FFF_0000, 2);
        chk("lh_hi_sel", {28'd0, cap_sel}, 32'hC);

        // SB lane 1 replication
        push(1'b0, 32'd0, 1'b0, 1'b0);
        issue(`STORE, 3'b000, 32'h0000_0101, 32'h1234_565A);
        txn("sb", 0, 32'd0, 2);
        chk("sb_sel", {28'd0, cap_sel}, 32'h2);
        chk("sb_data", cap_data, 32'h5A5A_5A5A);

        // lower half, zero vs sign extension
        push(1'b1, 32'h0000_8765, 1'b0, 1'b0);
        issue(`LOAD, 3'b101, 32'h0000_0300, 32'd0);
        txn("lhu_lo", 1, 32'h1234_8765, 3);
        chk("lhu_lo_sel", {28'd0, cap_sel}, 32'h3);

        push(1'b1, 32'hFFFF_8765, 1'b0, 1'b0);
        issue(`LOAD, 3'b001, 32'h0000_0300, 32'd0);
        txn("lh_lo", 0, 32'h1234_8765, 2);

        // timeout: no ack at all
        push(1'b1, 32'd0, 1'b1, 1'b0);
        issue(`LOAD, 3'b010, 32'h0000_0400, 32'd0);
        txn("lw_timeout", -1, 32'd0, TO + 1);
        chk("lw_timeout_stall_cycles", stall_n, TO);
        chk("lw_timeout_cyc_dropped", {31'd0, o_wb_cyc}, 32'd0);

        // ack on the very cycle the timeout would fire: ack wins
        push(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
        issue(`LOAD, 3'b010, 32'h0000_0500, 32'd0);
        txn("lw_ack_at_limit", TO - 1, 32'hCAFE_F00D, TO + 1);

        // reset in the middle of ACCESS
        issue(`LOAD, 3'b010, 32'h0000_0600, 32'd0);
        @(negedge i_clk);
        chk("midrst_pre_cyc", {31'd0, o_wb_cyc}, 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_cyc", {31'd0, o_wb_cyc}, 32'd0);
        chk("midrst_stb", {31'd0, o_wb_stb}, 32'd0);
        chk("midrst_stall", {31'd0, o_stall}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            chk("midrst_no_done", {31'd0, o_done}, 32'd0);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // R-type after reset: done next cycle, no bus activity
        push(1'b1, 32'd0, 1'b0, 1'b0);
        issue(`RTYPE, 3'b000, 32'h0000_0700, 32'd0);
        txn("rtype", -1, 32'd0, 1);
        chk("rtype_no_cyc", {31'd0, saw_cyc}, 32'd0);

        // misaligned word access
`ifdef ASRV32_MISALIGN_TRAP_EN
        push(1'b1, 32'd0, 1'b0, 1'b1);
        issue(`LOAD, 3'b010, 32'h0000_0101, 32'd0);
        txn("lw_misal_trap", -1, 32'd0, 1);
        chk("lw_misal_no_cyc", {31'd0, saw_cyc}, 32'd0);
`else
        push(1'b1, 32'h1122_3344, 1'b0, 1'b0);
        issue(`LOAD, 3'b010, 32'h0000_0101, 32'd0);
        txn("lw_misal_aligned", 0, 32'h1122_3344, 2);
        chk("lw_misal_addr", cap_addr, 32'h0000_0100);
        chk("lw_misal_sel", {28'd0, cap_sel}, 32'hF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/asrv32_memoryaccess.md
Name: asrv32_memoryaccess

Overview:
- Memory-access stage of the ASRV32 core. Sits directly upstream of the writeback stage and supplies its load-data input.
- Converts LOAD/STORE instructions into single Wishbone-classic data-bus transactions:
  - byte-lane select generation
  - store data replication
  - load extraction and sign/zero extension
- Stalls the core while a transaction is outstanding. Aborts on a bus timeout.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for i_wb_ack before abort (8-bit counter, 1..255)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_ce  in  1  one-cycle pulse: instruction enters memory stage
i_opcode  in  `OPCODE_WIDTH  one-hot opcode (`LOAD, `STORE bits used)
i_funct3  in  3  access size/sign
i_addr  in  32  effective address (ALU result)
i_rs2_data  in  32  store source data
o_load_data  out  32  extended load result, valid from o_done until next i_ce
o_stall  out  1  high while transaction in flight
o_done  out  1  one-cycle pulse: stage complete
o_bus_err  out  1  one-cycle pulse with o_done on timeout
o_misaligned  out  1  one-cycle pulse with o_done on misaligned access (optional feature)
o_wb_cyc, o_wb_stb  out  1 each  bus cycle/strobe
o_wb_we  out  1  write enable
o_wb_addr  out  32  word-aligned address {addr[31:2],2'b00}
o_wb_data  out  32  write data
o_wb_sel  out  4  byte lanes
i_wb_ack  in  1  bus acknowledge
i_wb_data  in  32  read data

Behaviour:
- Reset:
  - Async clear. All outputs are 0. State is IDLE. Timeout counter is 0.
  - Reset mid-transaction: cyc/stb drop immediately. No o_done is issued.
- States: IDLE, ACCESS.
- IDLE, i_ce with LOAD or STORE:
  - Register addr, funct3, sel and data.
  - Assert cyc, stb and o_stall on the next edge. Go to ACCESS.
  - o_wb_we = STORE.
- IDLE, i_ce with any other opcode:
  - o_done pulses next cycle. No bus activity. o_load_data = 0.
- i_ce while in ACCESS: ignored. Upstream must not issue i_ce while o_stall is high.
- Lane select:
  - SB: 4'b0001<<addr[1:0]
  - SH: addr[1] ? 4'b1100 : 4'b0011
  - SW/LW: 4'b1111
  - Loads drive sel for their width the same way.
- Store data:
  - SB: {4{rs2[7:0]}}
  - SH: {2{rs2[15:0]}}
  - SW: rs2
- funct3 decode:
  - 000 byte, 001 half, 010 word.
  - funct3[2]=1 means zero-extend (LBU/LHU).
  - Reserved 011/110/111 are treated as word.
- ACCESS, edge where i_wb_ack=1:
  - Drop cyc/stb. Clear o_stall. Pulse o_done. Go to IDLE.
  - For a load, o_load_data = extract(i_wb_data >> 8*addr[1:0]) with sign/zero extension; it updates on that same edge.
  - Minimum latency i_ce→o_done: 2 cycles.
- Timeout:
  - The counter increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop cyc/stb, pulse o_done and o_bus_err, set o_load_data = 0, go to IDLE.
  - If ack arrives on the timeout cycle, ack wins and no error is flagged.
- Counter clears on entry to ACCESS.
- o_load_data holds its value until the next completion.

Optional Feature:
- Macro ASRV32_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access is half with addr[0]=1, or word with addr[1:0]≠0.
  - It issues no bus cycle. o_done and o_misaligned pulse the cycle after i_ce. o_load_data = 0.
- Undefined:
  - o_misaligned is tied 0.
  - Half accesses ignore addr[0]. Word accesses ignore addr[1:0] (the aligned word is accessed).

Test Plan:
- SW addr 0x104, rs2 0xDEADBEEF, ack after 3 cycles -> wb_addr 0x104, sel 1111, data 0xDEADBEEF, we=1; o_stall high 3 cycles; o_done once.
- LB addr 0x203, i_wb_data 0x80112233, ack immediate -> o_load_data 0xFFFFFF80; LBU same -> 0x00000080; o_done 2 cycles after i_ce.
- SH addr 0x302, rs2 0x0000ABCD -> sel 1100, data 0xABCDABCD; LH from 0x302 with bus 0x7FFF0000 -> 0x00007FFF.
- LW with no ack, TIMEOUT_CYCLES=4 -> cyc drops after 4 ACCESS cycles; o_bus_err and o_done pulse together; o_load_data 0.
- Reset asserted mid-ACCESS -> cyc/stb/o_stall 0 immediately, no o_done; R-type i_ce afterwards -> o_done next cycle, no cyc.
- With ASRV32_MISALIGN_TRAP_EN, LW addr 0x101 -> no cyc, o_misaligned and o_done pulse; without the macro -> access to 0x100, sel 1111.
